// File: rtl/chan_mux_pkg.sv
// Shared types for the chan_mux_sched channel selector.
package chan_mux_pkg;

    // Channel selection policy, driven straight from the mode pin.
    typedef enum logic {
        MANUAL      = 1'b0,
        ROUND_ROBIN = 1'b1
    } mux_mode_e;

    // Occupancy of the single output register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } mux_state_e;

endpackage : chan_mux_pkg

// File: rtl/chan_mux_sched_rr_picker.sv
// rr_picker: purely combinational rotate-priority pick.
// Returns the first requesting index found scanning ptr, ptr+1, ... modulo N_CH.
module rr_picker #(
    parameter  int N_CH  = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

    // Scan offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise a path with no request
        // would leave it unassigned and infer a latch.
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            automatic int k = (int'(ptr) + i) % N_CH;
            if (req[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(k);
            end
        end
    end

endmodule : rr_picker

// File: rtl/chan_mux_sched.sv
// chan_mux_sched: registered N-channel selector with valid/ready on each input and on the output.
// MANUAL mode takes the channel from sel; ROUND_ROBIN mode scans valid channels fairly from rr_ptr.
// Optional feature: define CHAN_MUX_PARITY_EN to add out_par (even parity of out_data, registered).
module chan_mux_sched
    import chan_mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int W     = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready
`ifdef CHAN_MUX_PARITY_EN
    ,
    output logic              out_par
`endif
);

    mux_state_e       r_state;
    mux_state_e       w_state_next;
    logic [W-1:0]     r_data;
    logic [SEL_W-1:0] r_ch;
    logic [SEL_W-1:0] r_rr_ptr;

    mux_mode_e        w_mode;
    logic             w_man_vld;
    logic             w_rr_vld;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_cand_vld;
    logic [SEL_W-1:0] w_cand_idx;
    logic             w_slot_free;
    logic             w_grant;
    logic [SEL_W-1:0] w_ptr_next;

    assign w_mode = mux_mode_e'(mode);

    // An out-of-range sel never names a channel, so it can never be granted.
    assign w_man_vld = (int'(sel) < N_CH) ? in_valid[sel] : 1'b0;

    rr_picker #(.N_CH(N_CH)) u_rr_picker (
        .req     (in_valid),
        .ptr     (r_rr_ptr),
        .gnt_vld (w_rr_vld),
        .gnt_idx (w_rr_idx)
    );

    // Choose the candidate channel for the active mode.
    always_comb begin
        w_cand_vld = 1'b0;
        w_cand_idx = '0;
        if (w_mode == ROUND_ROBIN) begin
            w_cand_vld = w_rr_vld;
            w_cand_idx = w_rr_idx;
        end else begin
            w_cand_vld = w_man_vld;
            w_cand_idx = sel;
        end
    end

    // The output register can load when empty or when its word leaves this cycle.
    assign w_slot_free = (r_state == EMPTY) || out_ready;
    assign w_grant     = !rst && w_slot_free && w_cand_vld;
    assign w_ptr_next  = (w_cand_idx == SEL_W'(N_CH - 1)) ? '0 : w_cand_idx + 1'b1;

    // One-hot accept back to the granted producer only.
    always_comb begin
        in_ready = '0;
        if (w_grant) begin
            in_ready[w_cand_idx] = 1'b1;
        end
    end

    // Next state: a grant refills the register, otherwise a consumed word empties it.
    always_comb begin
        w_state_next = r_state;
        if (w_grant) begin
            w_state_next = FULL;
        end else if (out_ready) begin
            w_state_next = EMPTY;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
        // order of statements across always_ff blocks cannot change the result.
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output word, source channel and round-robin pointer; the word only changes on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_ch     <= '0;
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_data <= in_data[int'(w_cand_idx)*W +: W];
            r_ch   <= w_cand_idx;
            if (w_mode == ROUND_ROBIN) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

`ifdef CHAN_MUX_PARITY_EN
    logic r_par;

    // Parity is captured alongside the word it protects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_grant) begin
            r_par <= ^in_data[int'(w_cand_idx)*W +: W];
        end
    end

    assign out_par = r_par;
`endif

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = (r_state == FULL);

endmodule : chan_mux_sched
